// File: rtl/uart_core.sv
// UART core: fixed-rate transmitter, mid-bit sampling receiver and a small RX FIFO.
// Both serial paths share the same state set:
//   state | meaning
//   IDLE  | line idle, waiting for a byte (TX) or a falling edge (RX)
//   START | start bit in progress
//   DATA  | data bits, LSB first
//   STOP  | stop bit in progress
module uart_core #(
  parameter int CLK_DIV  = 16,
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  input  logic              uart_rx,
  output logic              uart_tx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [BW-1:0]     tx_idx;
  logic [DATA_W-1:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_ready <= 1'b1;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shift <= tx_data;
            tx_cnt   <= BIT_LAST;
            tx_ready <= 1'b0;
            uart_tx  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= BIT_LAST;
            tx_idx   <= '0;
            uart_tx  <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_idx == IDX_LAST) begin
              uart_tx  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              uart_tx  <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == '0) begin
            tx_ready <= 1'b1;
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // [1] is the synchronized line; [2] is its previous value for edge detection
  logic [2:0] rx_sync;
  logic       rx_line;

  assign rx_line = rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 3'b111;
    else        rx_sync <= {rx_sync[1:0], uart_rx};
  end

  state_t            rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [BW-1:0]     rx_idx;
  logic [DATA_W-1:0] rx_shift;
  logic              push;

  assign push = (rx_state == STOP) && (rx_cnt == '0) && rx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_sync[2] && !rx_line) begin
            rx_cnt   <= HALF_LAST;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (rx_line) begin
              rx_state <= IDLE;
            end else begin
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_state <= DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_line, rx_shift[DATA_W-1:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_idx == IDX_LAST) rx_state <= STOP;
            else                    rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == '0) begin
            rx_frame_err <= !rx_line;
            rx_state     <= IDLE;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] mem [RX_DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              full, pop, wr;

  assign rx_valid = (wptr != rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop      = rx_valid && rx_ready;
  // A pop in the same cycle frees the slot being written, so full+pop still accepts
  assign wr       = push && (!full || pop);
  assign rx_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      rx_overrun <= 1'b0;
      for (int i = 0; i < RX_DEPTH; i++) mem[i] <= '0;
    end else begin
      rx_overrun <= push && full && !pop;
      if (wr) begin
        mem[wptr[AW-1:0]] <= rx_shift;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule
